// File: rtl/cache_controller_if.sv
// CPU load/store port and main-memory port of the direct-mapped cache controller.
// The controller binds the slave modport; the CPU/memory environment drives the master side.
interface cache_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_controller.sv
// Write-back, write-allocate, direct-mapped cache of one-word lines with its tag/valid/dirty/data
// arrays; hits complete in COMPARE, misses run an optional write-back followed by a refill.
module cache_controller #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 11
) (
    input logic               clk,
    input logic               rst,
    cache_controller_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPARE   = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_req_we;
    logic [ADDR_W-3:0]   r_req_word;
    logic [DATA_W-1:0]   r_req_wdata;
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [DATA_W-1:0]   r_data [LINES];

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_req_tag;
    logic                w_hit;
    logic                w_latch;
    logic                w_store;
    logic                w_refill;
    logic [1:0]          w_unused_addr_lsb;

    // Byte offset is dropped when latching: accesses are whole words.
    assign w_unused_addr_lsb = bus.cpu_addr[1:0];
    assign w_idx             = r_req_word[INDEX_W-1:0];
    assign w_req_tag         = r_req_word[ADDR_W-3:INDEX_W];
    assign w_hit             = r_valid[w_idx] && (r_tag[w_idx] == w_req_tag);

    // State register and request capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_we    <= 1'b0;
            r_req_word  <= '0;
            r_req_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_req_we    <= bus.cpu_we;
                r_req_word  <= bus.cpu_addr[ADDR_W-1:2];
                r_req_wdata <= bus.cpu_wdata;
            end
        end
    end

    // Line status bits; a refill installs a clean line, a store hit marks it dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_refill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_store) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are not reset; rst only suppresses writes so an abandoned refill leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst && (w_refill || w_store)) begin
            r_data[w_idx] <= w_refill ? bus.mem_rdata : r_req_wdata;
        end
        if (!rst && w_refill) begin
            r_tag[w_idx] <= w_req_tag;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next        = r_state;
        w_latch       = 1'b0;
        w_store       = 1'b0;
        w_refill      = 1'b0;
        bus.cpu_ready = 1'b0;
        bus.cpu_rdata = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    w_latch = 1'b1;
                    w_next  = S_COMPARE;
                end else begin
                    w_next  = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (w_hit) begin
                    bus.cpu_ready = 1'b1;
                    w_next        = S_IDLE;
                    if (r_req_we) begin
                        w_store = 1'b1;
                    end else begin
                        bus.cpu_rdata = r_data[w_idx];
                    end
                end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                    w_next = S_WRITEBACK;
                end else begin
                    w_next = S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {r_tag[w_idx], w_idx, 2'b00};
                bus.mem_wdata = r_data[w_idx];
                if (bus.mem_ack) begin
                    w_next = S_ALLOCATE;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_ALLOCATE: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b0;
                bus.mem_addr = {w_req_tag, w_idx, 2'b00};
                if (bus.mem_ack) begin
                    w_refill = 1'b1;
                    w_next   = S_COMPARE;
                end else begin
                    w_next   = S_ALLOCATE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: scripted CPU accesses with an inline memory responder
// whose latencies and data are fixed per step, checked cycle by cycle against hand-derived values.
module tb_cache_controller;
    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cache_controller_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cache_controller #(.ADDR_W(32), .DATA_W(32), .INDEX_W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, " cpu_ready"}, bus.cpu_ready, 1'b0);
        chk ({tag, " cpu_rdata"}, bus.cpu_rdata, 32'h0000_0000);
        chk1({tag, " mem_req"},   bus.mem_req,   1'b0);
        chk1({tag, " mem_we"},    bus.mem_we,    1'b0);
        chk ({tag, " mem_addr"},  bus.mem_addr,  32'h0000_0000);
        chk ({tag, " mem_wdata"}, bus.mem_wdata, 32'h0000_0000);
    endtask

    // One CPU access. l1 = write-back latency (0: none expected), l2 = refill latency (0: hit).
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          input int l1, input logic [31:0] wb_addr, input logic [31:0] wb_data,
                          input int l2, input logic [31:0] rf_addr, input logic [31:0] rf_data,
                          input logic [31:0] exp_rdata, input bit toggle);
        int exp_ready;
        exp_ready = (l2 == 0) ? 1 : 2 + l1 + l2;
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        for (int c = 1; c <= exp_ready; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (c == exp_ready) begin
                chk1({tag, " ready"}, bus.cpu_ready, 1'b1);
                if (!we) chk({tag, " rdata"}, bus.cpu_rdata, exp_rdata);
                chk1({tag, " mem_req at ready"}, bus.mem_req, 1'b0);
                bus.cpu_req = 1'b0;
            end else if (c == 1) begin
                chk1({tag, " miss no ready"}, bus.cpu_ready, 1'b0);
                chk1({tag, " compare mem_req"}, bus.mem_req, 1'b0);
            end else if (c < 2 + l1) begin
                chk1({tag, " wb busy ready"}, bus.cpu_ready, 1'b0);
                chk1({tag, " wb mem_req"},    bus.mem_req,   1'b1);
                chk1({tag, " wb mem_we"},     bus.mem_we,    1'b1);
                chk ({tag, " wb mem_addr"},   bus.mem_addr,  wb_addr);
                chk ({tag, " wb mem_wdata"},  bus.mem_wdata, wb_data);
                bus.mem_ack = (c == 1 + l1);
            end else begin
                chk1({tag, " rf busy ready"}, bus.cpu_ready, 1'b0);
                chk1({tag, " rf mem_req"},    bus.mem_req,   1'b1);
                chk1({tag, " rf mem_we"},     bus.mem_we,    1'b0);
                chk ({tag, " rf mem_addr"},   bus.mem_addr,  rf_addr);
                bus.mem_ack   = (c == 1 + l1 + l2);
                bus.mem_rdata = rf_data;
            end
            if (toggle && c > 1 && c < exp_ready) bus.cpu_req = c[0];
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h0000_0000;
        bus.cpu_wdata = 32'h0000_0000;
        bus.mem_rdata = 32'h0000_0000;
        bus.mem_ack   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_quiet("reset");

        // Cold load miss, L=3: ready 5 cycles after accept.
        access("cold_load", 1'b0, 32'h0000_0004, 32'h0, 0, 32'h0, 32'h0,
               3, 32'h0000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        // Hit with ignored byte offset.
        access("hit_load", 1'b0, 32'h0000_0006, 32'h0, 0, 32'h0, 32'h0,
               0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access("store_hit", 1'b1, 32'h0000_0004, 32'h1234_5678, 0, 32'h0, 32'h0,
               0, 32'h0, 32'h0, 32'h0, 1'b0);
        // Dirty eviction: write-back L1=2, refill L2=1 (ack in the rise cycle).
        access("evict", 1'b0, 32'h0000_2004, 32'h0, 2, 32'h0000_0004, 32'h1234_5678,
               1, 32'h0000_2004, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
        access("reload", 1'b0, 32'h0000_0004, 32'h0, 0, 32'h0, 32'h0,
               2, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678, 1'b0);
        // Long stall with a toggling cpu_req.
        access("stall", 1'b0, 32'h0000_2004, 32'h0, 0, 32'h0, 32'h0,
               10, 32'h0000_2004, 32'h5555_AAAA, 32'h5555_AAAA, 1'b1);

        // Stray mem_ack while idle.
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk_quiet("stray_ack");
        access("after_stray", 1'b0, 32'h0000_2004, 32'h0, 0, 32'h0, 32'h0,
               0, 32'h0, 32'h0, 32'h5555_AAAA, 1'b0);

        // Reset during the refill wait, coinciding with mem_ack.
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h0000_4004;
        @(negedge clk);
        chk1("rst_alloc compare ready", bus.cpu_ready, 1'b0);
        @(negedge clk);
        chk1("rst_alloc mem_req", bus.mem_req, 1'b1);
        chk ("rst_alloc mem_addr", bus.mem_addr, 32'h0000_4004);
        @(negedge clk);
        rst           = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        bus.cpu_req   = 1'b0;
        @(negedge clk);
        rst         = 1'b0;
        bus.mem_ack = 1'b0;
        chk_quiet("rst_alloc after");
        access("post_rst_miss", 1'b0, 32'h0000_2004, 32'h0, 0, 32'h0, 32'h0,
               1, 32'h0000_2004, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0);

        // Store miss to index 2047, then its eviction.
        access("store_miss", 1'b1, 32'h0000_1FFC, 32'hA5A5_A5A5, 0, 32'h0, 32'h0,
               2, 32'h0000_1FFC, 32'h0101_0101, 32'h0, 1'b0);
        access("evict_2047", 1'b0, 32'h0000_3FFC, 32'h0, 1, 32'h0000_1FFC, 32'hA5A5_A5A5,
               1, 32'h0000_3FFC, 32'h3C3C_3C3C, 32'h3C3C_3C3C, 1'b0);

        @(negedge clk);
        chk_quiet("final idle");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
